// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the two-requester SPI bus arbiter.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XFER  = 2'd2,
        GAP   = 2'd3
    } arb_state_e;

    localparam logic REQ_A2D   = 1'b0;
    localparam logic REQ_INERT = 1'b1;

    localparam int CMD_W = 16;

endpackage : spi_arb_pkg

// File: rtl/spi_bus_arb_if.sv
// Requester handshakes, SPI master hookup and slave selects of the arbiter.
interface spi_bus_arb_if;
    import spi_arb_pkg::*;

    logic             req0_vld;
    logic [CMD_W-1:0] req0_cmd;
    logic             req0_lock;
    logic             req0_ack;
    logic             req0_done;

    logic             req1_vld;
    logic [CMD_W-1:0] req1_cmd;
    logic             req1_lock;
    logic             req1_ack;
    logic             req1_done;

    logic [CMD_W-1:0] rd_data;

    logic             m_wrt;
    logic [CMD_W-1:0] m_cmd;
    logic             m_done;
    logic [CMD_W-1:0] m_rd_data;
    logic             m_SS_n;

    logic             ss0_n;
    logic             ss1_n;
    logic             owner;
    logic             busy;

    // Arbiter side.
    modport slave (
        input  req0_vld, req0_cmd, req0_lock,
        input  req1_vld, req1_cmd, req1_lock,
        input  m_done, m_rd_data, m_SS_n,
        output req0_ack, req0_done, req1_ack, req1_done,
        output rd_data, m_wrt, m_cmd, ss0_n, ss1_n, owner, busy
    );

    // Requesters / SPI master / slaves side.
    modport master (
        output req0_vld, req0_cmd, req0_lock,
        output req1_vld, req1_cmd, req1_lock,
        output m_done, m_rd_data, m_SS_n,
        input  req0_ack, req0_done, req1_ack, req1_done,
        input  rd_data, m_wrt, m_cmd, ss0_n, ss1_n, owner, busy
    );

endinterface : spi_bus_arb_if

// File: rtl/spi_arb_rr_sel.sv
// Combinational 2-way round-robin pick; a forced owner keeps the bus while it still requests.
module spi_arb_rr_sel (
    input  logic [1:0] vld,
    input  logic       owner,
    input  logic       force_owner,
    output logic       pick,
    output logic       pick_valid
);

    always_comb begin
        pick_valid = |vld;
        if (force_owner && vld[owner]) begin
            pick = owner;
        end else if (&vld) begin
            pick = ~owner;
        end else begin
            pick = vld[1];
        end
    end

endmodule : spi_arb_rr_sel

// File: rtl/spi_bus_arb.sv
// Shares one SPI master between the A2D (0) and inertial (1) requesters, round-robin.
// Define SPI_ARB_LOCK_EN to let a locked owner keep the bus for up to MAX_LOCK transactions.
module spi_bus_arb
    import spi_arb_pkg::*;
#(
    parameter int IDLE_GAP = 2,
    parameter int MAX_LOCK = 4
) (
    input logic          clk,
    input logic          rst_n,
    spi_bus_arb_if.slave bus
);

    localparam int GAP_W = (IDLE_GAP < 2) ? 1 : $clog2(IDLE_GAP);
    localparam int LCK_W = (MAX_LOCK < 2) ? 1 : $clog2(MAX_LOCK + 1);

    arb_state_e       state_q, state_d;
    logic             owner_q, owner_d;
    logic [CMD_W-1:0] m_cmd_q, m_cmd_d;
    logic [CMD_W-1:0] rd_data_q, rd_data_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [LCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic             force_q, force_d;

    logic             pick;
    logic             pick_valid;
    logic             lock_req;
    logic             xfer_phase;

`ifdef SPI_ARB_LOCK_EN
    assign lock_req = owner_q ? bus.req1_lock : bus.req0_lock;
`else
    logic unused_lock;
    assign lock_req    = 1'b0;
    assign unused_lock = bus.req0_lock ^ bus.req1_lock;
`endif

    spi_arb_rr_sel u_rr_sel (
        .vld         ({bus.req1_vld, bus.req0_vld}),
        .owner       (owner_q),
        .force_owner (force_q),
        .pick        (pick),
        .pick_valid  (pick_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= REQ_INERT;
            m_cmd_q    <= '0;
            rd_data_q  <= '0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            gap_q      <= '0;
            lock_cnt_q <= '0;
            force_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            m_cmd_q    <= m_cmd_d;
            rd_data_q  <= rd_data_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            gap_q      <= gap_d;
            lock_cnt_q <= lock_cnt_d;
            force_q    <= force_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        m_cmd_d    = m_cmd_q;
        rd_data_d  = rd_data_q;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        gap_d      = gap_q;
        lock_cnt_d = lock_cnt_q;
        force_d    = force_q;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d = pick;
                    m_cmd_d = pick ? bus.req1_cmd : bus.req0_cmd;
                    force_d = 1'b0;
                    if (pick != owner_q) lock_cnt_d = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                state_d = XFER;
            end
            XFER: begin
                if (bus.m_done) begin
                    rd_data_d = bus.m_rd_data;
                    done0_d   = (owner_q == REQ_A2D);
                    done1_d   = (owner_q == REQ_INERT);
                    gap_d     = '0;
                    state_d   = (IDLE_GAP == 0) ? IDLE : GAP;
                    // The lock run ends itself once MAX_LOCK back-to-back transactions are used.
                    if (lock_req && (lock_cnt_q < LCK_W'(MAX_LOCK - 1))) begin
                        lock_cnt_d = lock_cnt_q + LCK_W'(1);
                        force_d    = 1'b1;
                    end else begin
                        lock_cnt_d = '0;
                        force_d    = 1'b0;
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_W'(IDLE_GAP - 1)) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Selects only follow the master while the owner actually holds the bus.
    assign xfer_phase    = (state_q == GRANT) || (state_q == XFER);
    assign bus.ss0_n     = (xfer_phase && (owner_q == REQ_A2D))   ? bus.m_SS_n : 1'b1;
    assign bus.ss1_n     = (xfer_phase && (owner_q == REQ_INERT)) ? bus.m_SS_n : 1'b1;

    assign bus.m_wrt     = (state_q == GRANT);
    assign bus.req0_ack  = (state_q == GRANT) && (owner_q == REQ_A2D);
    assign bus.req1_ack  = (state_q == GRANT) && (owner_q == REQ_INERT);
    assign bus.req0_done = done0_q;
    assign bus.req1_done = done1_q;
    assign bus.m_cmd     = m_cmd_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.owner     = owner_q;
    assign bus.busy      = (state_q != IDLE);

endmodule : spi_bus_arb

// File: tb/tb_spi_bus_arb.sv
// Directed bench for spi_bus_arb: one instance with IDLE_GAP=2, one with IDLE_GAP=0.
module tb_spi_bus_arb;
    import spi_arb_pkg::*;

    localparam int GAP_A = 2;

`ifdef SPI_ARB_LOCK_EN
    localparam logic [4:0] ORD_LOCK4 = 5'b10000;
    localparam logic [2:0] ORD_DROP  = 3'b100;
`else
    localparam logic [4:0] ORD_LOCK4 = 5'b01010;
    localparam logic [2:0] ORD_DROP  = 3'b010;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    spi_bus_arb_if bus ();
    spi_bus_arb_if bus0 ();

    spi_bus_arb #(.IDLE_GAP(GAP_A), .MAX_LOCK(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    spi_bus_arb #(.IDLE_GAP(0), .MAX_LOCK(4)) u_dut_nogap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] cmd_of(input logic who);
        return who ? 16'hB000 : 16'hA000;
    endfunction

    task automatic rst_pulse();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Waits for the grant, plays the SPI master for one frame and checks the completion.
    task automatic serve(input logic who, input logic [15:0] cmd, input logic [15:0] rdat,
                         input int exp_wait, input bit drop);
        int w;
        w = 0;
        while (bus.m_wrt !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        chk("wrt_seen", 32'(bus.m_wrt), 32'(1));
        if (exp_wait >= 0) chk("grant_latency", 32'(w), 32'(exp_wait));
        chk("owner", 32'(bus.owner), 32'(who));
        chk("m_cmd", 32'(bus.m_cmd), 32'(cmd));
        chk("ack0", 32'(bus.req0_ack), 32'(!who));
        chk("ack1", 32'(bus.req1_ack), 32'(who));
        if (drop) begin
            bus.req0_vld = 1'b0;
            bus.req1_vld = 1'b0;
        end
        bus.m_SS_n = 1'b0;
        #1;
        chk("ss_owner", 32'(who ? bus.ss1_n : bus.ss0_n), 32'(0));
        chk("ss_other", 32'(who ? bus.ss0_n : bus.ss1_n), 32'(1));
        tick();
        chk("wrt_one_cycle", 32'(bus.m_wrt), 32'(0));
        chk("ss_owner_xfer", 32'(who ? bus.ss1_n : bus.ss0_n), 32'(0));
        bus.m_done    = 1'b1;
        bus.m_rd_data = rdat;
        tick();
        bus.m_done    = 1'b0;
        bus.m_SS_n    = 1'b1;
        bus.m_rd_data = 16'hDEAD;
        #1;
        chk("done_owner", 32'(who ? bus.req1_done : bus.req0_done), 32'(1));
        chk("done_other", 32'(who ? bus.req0_done : bus.req1_done), 32'(0));
        chk("rd_data", 32'(bus.rd_data), 32'(rdat));
    endtask

    initial begin
        rst_n = 1'b0;
        bus.req0_vld  = 1'b0; bus.req0_cmd = '0; bus.req0_lock = 1'b0;
        bus.req1_vld  = 1'b0; bus.req1_cmd = '0; bus.req1_lock = 1'b0;
        bus.m_done    = 1'b0; bus.m_rd_data = '0; bus.m_SS_n = 1'b1;
        bus0.req0_vld = 1'b0; bus0.req0_cmd = '0; bus0.req0_lock = 1'b0;
        bus0.req1_vld = 1'b0; bus0.req1_cmd = '0; bus0.req1_lock = 1'b0;
        bus0.m_done   = 1'b0; bus0.m_rd_data = '0; bus0.m_SS_n = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_m_wrt", 32'(bus.m_wrt), 32'(0));
        chk("rst_m_cmd", 32'(bus.m_cmd), 32'(0));
        chk("rst_rd_data", 32'(bus.rd_data), 32'(0));
        chk("rst_ss0", 32'(bus.ss0_n), 32'(1));
        chk("rst_ss1", 32'(bus.ss1_n), 32'(1));
        chk("rst_owner", 32'(bus.owner), 32'(1));
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_ack0", 32'(bus.req0_ack), 32'(0));
        chk("rst_ack1", 32'(bus.req1_ack), 32'(0));
        chk("rst_done0", 32'(bus.req0_done), 32'(0));
        chk("rst_done1", 32'(bus.req1_done), 32'(0));
        rst_n = 1'b1;
        tick();

        // Single requester 0 transaction, then a request raised during the gap
        bus.req0_cmd = 16'h2000;
        bus.req0_vld = 1'b1;
        serve(1'b0, 16'h2000, 16'h0ABC, 1, 1'b1);
        chk("busy_in_gap", 32'(bus.busy), 32'(1));
        chk("ss1_in_gap", 32'(bus.ss1_n), 32'(1));
        bus.req1_cmd = 16'h1234;
        bus.req1_vld = 1'b1;
        serve(1'b1, 16'h1234, 16'h5555, GAP_A + 1, 1'b1);
        tick();
        tick();
        chk("idle_busy", 32'(bus.busy), 32'(0));
        chk("idle_rd_hold", 32'(bus.rd_data), 32'(16'h5555));
        tick();
        chk("no_phantom_wrt", 32'(bus.m_wrt), 32'(0));

        // Both requesters held: strict alternation starting with requester 0
        rst_pulse();
        bus.req0_cmd = cmd_of(1'b0);
        bus.req1_cmd = cmd_of(1'b1);
        bus.req0_vld = 1'b1;
        bus.req1_vld = 1'b1;
        for (int i = 0; i < 6; i++) begin
            serve(1'(i % 2), cmd_of(1'(i % 2)), 16'(16'h0100 + i),
                  (i == 0) ? 1 : GAP_A + 1, i == 5);
        end

        // Requester 0 asks for the lock with both requesters held
        rst_pulse();
        bus.req0_lock = 1'b1;
        bus.req0_vld  = 1'b1;
        bus.req1_vld  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            serve(ORD_LOCK4[i], cmd_of(ORD_LOCK4[i]), 16'(16'h0200 + i),
                  (i == 0) ? 1 : GAP_A + 1, i == 4);
        end

        // Lock released on the second transaction
        rst_pulse();
        bus.req0_vld = 1'b1;
        bus.req1_vld = 1'b1;
        serve(ORD_DROP[0], cmd_of(ORD_DROP[0]), 16'h0300, 1, 1'b0);
        bus.req0_lock = 1'b0;
        serve(ORD_DROP[1], cmd_of(ORD_DROP[1]), 16'h0301, GAP_A + 1, 1'b0);
        serve(ORD_DROP[2], cmd_of(ORD_DROP[2]), 16'h0302, GAP_A + 1, 1'b1);

        // Asynchronous reset in the middle of a transfer
        rst_pulse();
        tick();
        tick();
        bus.req1_cmd = 16'hC001;
        bus.req1_vld = 1'b1;
        tick();
        chk("r5_wrt", 32'(bus.m_wrt), 32'(1));
        chk("r5_ack1", 32'(bus.req1_ack), 32'(1));
        bus.m_SS_n = 1'b0;
        tick();
        chk("r5_ss1_low", 32'(bus.ss1_n), 32'(0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("r5_wrt_rst", 32'(bus.m_wrt), 32'(0));
        chk("r5_ss0_rst", 32'(bus.ss0_n), 32'(1));
        chk("r5_ss1_rst", 32'(bus.ss1_n), 32'(1));
        chk("r5_busy_rst", 32'(bus.busy), 32'(0));
        chk("r5_m_cmd_rst", 32'(bus.m_cmd), 32'(0));
        bus.m_SS_n   = 1'b1;
        bus.req0_cmd = 16'hA000;
        bus.req0_vld = 1'b1;
        tick();
        rst_n = 1'b1;
        serve(1'b0, 16'hA000, 16'h7777, 1, 1'b1);

        // IDLE_GAP=0 instance: m_wrt two cycles after m_done with requester 1 held
        bus0.req1_cmd = 16'h3003;
        bus0.req1_vld = 1'b1;
        tick();
        chk("ng_wrt", 32'(bus0.m_wrt), 32'(1));
        chk("ng_ack1", 32'(bus0.req1_ack), 32'(1));
        chk("ng_ack0", 32'(bus0.req0_ack), 32'(0));
        tick();
        chk("ng_wrt_low", 32'(bus0.m_wrt), 32'(0));
        bus0.m_done    = 1'b1;
        bus0.m_rd_data = 16'h4321;
        tick();
        bus0.m_done = 1'b0;
        chk("ng_done1", 32'(bus0.req1_done), 32'(1));
        chk("ng_rd", 32'(bus0.rd_data), 32'(16'h4321));
        chk("ng_idle_busy", 32'(bus0.busy), 32'(0));
        chk("ng_wrt_done_cyc", 32'(bus0.m_wrt), 32'(0));
        tick();
        chk("ng_wrt_again", 32'(bus0.m_wrt), 32'(1));
        chk("ng_ack1_again", 32'(bus0.req1_ack), 32'(1));
        bus0.req1_vld = 1'b0;
        tick();
        bus0.m_done = 1'b1;
        tick();
        bus0.m_done = 1'b0;
        tick();
        chk("ng_end_busy", 32'(bus0.busy), 32'(0));
        chk("ng_end_wrt", 32'(bus0.m_wrt), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_spi_bus_arb
